wb_lsu_master: RTL and testbench

- Load/store bridge between the rv32i core's memory-stage bus (mem_addr/mem_wdata/mem_read/mem_write/mem_op) and the Wishbone interconnect's IO master port.
- Sits directly upstream of the interconnect.
- Converts RISC-V funct3 memory ops into byte selects and lane-aligned write data. Runs one classic Wishbone cycle per access. Stalls the pipeline until the cycle terminates, then returns sign- or zero-extended load data.

---
 rtl/wb_lsu_pkg.sv | 27 ++
 rtl/wb_lsu_master_lsu_align.sv | 65 ++++++
 rtl/wb_lsu_master.sv | 198 +++++++++++++++++++
 tb/tb_wb_lsu_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_lsu_pkg.sv
// +----------------------------------------------------------------------------+
// | wb_lsu_pkg: shared types and constants for the Wishbone load/store master. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package wb_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RETRY = 2'd2,
    DONE  = 2'd3
  } lsu_state_e;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

`default_nettype wire

// File: rtl/wb_lsu_master_lsu_align.sv
// +----------------------------------------------------------------------------+
// | lsu_align: byte-lane steering for stores and load result formatting.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module lsu_align
  import wb_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic        write,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  sel,
  output logic [31:0] wdata_aligned,
  output logic [31:0] rdata_fmt,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;

  assign shifted = rdata_raw >> {addr_lo, 3'b000};

  always_comb begin
    sel           = 4'b0000;
    wdata_aligned = 32'd0;
    rdata_fmt     = 32'd0;
    misaligned    = 1'b0;
    illegal       = 1'b0;
    case (op)
      OP_B, OP_BU: begin
        sel           = 4'b0001 << addr_lo;
        wdata_aligned = {4{wdata[7:0]}};
        rdata_fmt     = (op == OP_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'd0, shifted[7:0]};
      end
      OP_H, OP_HU: begin
        sel           = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_aligned = {2{wdata[15:0]}};
        rdata_fmt     = (op == OP_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'd0, shifted[15:0]};
        misaligned    = addr_lo[0];
      end
      OP_W: begin
        sel           = 4'b1111;
        wdata_aligned = wdata;
        rdata_fmt     = rdata_raw;
        misaligned    = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (write && (op == OP_BU || op == OP_HU)) begin
      illegal = 1'b1;
    end
    if (!write) begin
      wdata_aligned = 32'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_lsu_master.sv
// +----------------------------------------------------------------------------+
// | wb_lsu_master: stalls the core while one classic Wishbone cycle completes. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_lsu_master
  import wb_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RETRY_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] proc_addr,
  input  logic [31:0] proc_wdata,
  input  logic        proc_write,
  input  logic        proc_read,
  input  logic [2:0]  proc_op,
  output logic [31:0] proc_rdata,
  output logic        proc_stall_pipl,
  output logic        proc_err,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RTY_MAX  = RW'(RETRY_LIMIT);

  lsu_state_e  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  op_q, op_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rty_q, rty_d;

  logic        req;
  logic        in_idle;
  logic [2:0]  al_op;
  logic [1:0]  al_off;
  logic        al_write;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misaligned;
  logic        al_illegal;

  assign req     = proc_read | proc_write;
  assign in_idle = (state_q == IDLE);

  // While idle the aligner looks at the incoming request; afterwards at the latched one.
  assign al_op    = in_idle ? proc_op         : op_q;
  assign al_off   = in_idle ? proc_addr[1:0]  : off_q;
  assign al_write = in_idle ? proc_write      : we_q;

  lsu_align u_align (
    .op            (al_op),
    .addr_lo       (al_off),
    .write         (al_write),
    .wdata         (proc_wdata),
    .rdata_raw     (wb_dat_i),
    .sel           (al_sel),
    .wdata_aligned (al_wdata),
    .rdata_fmt     (al_rdata),
    .misaligned    (al_misaligned),
    .illegal       (al_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= 32'd0;
      off_q   <= 2'd0;
      op_q    <= 3'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      dat_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      rty_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      off_q   <= off_d;
      op_q    <= op_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      rty_q   <= rty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    off_d   = off_q;
    op_d    = op_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    tmo_d   = tmo_q;
    rty_d   = rty_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d = {proc_addr[31:2], 2'b00};
          off_d = proc_addr[1:0];
          op_d  = proc_op;
          we_d  = proc_write;
          sel_d = al_sel;
          dat_d = al_wdata;
          tmo_d = '0;
          rty_d = '0;
          if (al_illegal || al_misaligned) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (wb_err_i) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = DONE;
        end else if (wb_ack_i) begin
          if (!we_q) begin
            rdata_d = al_rdata;
          end
          state_d = DONE;
        end else if (wb_rty_i) begin
          if (rty_q == RTY_MAX) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            rty_d   = rty_q + RW'(1);
            state_d = RETRY;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST)) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      RETRY: begin
        tmo_d   = '0;
        state_d = BUS;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall is gated by rst so a reset releases the pipeline even with a request held.
  always_comb begin
    proc_stall_pipl = !rst && ((in_idle && req) || (state_q == BUS) || (state_q == RETRY));
    wb_cyc_o        = (state_q == BUS);
    wb_stb_o        = (state_q == BUS);
    wb_adr_o        = adr_q;
    wb_dat_o        = dat_q;
    wb_sel_o        = sel_q;
    wb_we_o         = we_q;
    wb_cti_o        = CTI_CLASSIC;
    wb_bte_o        = BTE_LINEAR;
    proc_rdata      = rdata_q;
    proc_err        = err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_lsu_master.sv
// +----------------------------------------------------------------------------+
// | tb_wb_lsu_master: directed bench with a configurable Wishbone slave.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] proc_addr = 32'd0;
  logic [31:0] proc_wdata = 32'd0;
  logic        proc_write = 1'b0;
  logic        proc_read = 1'b0;
  logic [2:0]  proc_op = 3'd0;
  logic [31:0] proc_rdata;
  logic        proc_stall_pipl;
  logic        proc_err;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;

  wb_lsu_master #(.TIMEOUT_CYCLES(8), .RETRY_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_write(proc_write),
    .proc_read(proc_read), .proc_op(proc_op), .proc_rdata(proc_rdata),
    .proc_stall_pipl(proc_stall_pipl), .proc_err(proc_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration, written only by the stimulus process.
  int          slv_wait = 0;
  int          slv_rty_n = 0;
  bit          slv_mute = 1'b0;
  int          slv_mode = 0;      // 0 normal, 1 err+ack together, 2 ack+rty together
  logic [31:0] slv_dat = 32'd0;

  // Slave state and monitors, written only by the slave process.
  int bus_cnt = 0;
  int rty_given = 0;
  bit cyc_prev = 1'b0;
  int cyc_tot = 0, seg_tot = 0, err_tot = 0, stall_tot = 0, stb_ne_cyc = 0;

  always @(negedge clk) begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    wb_dat_i = 32'd0;
    if (wb_cyc_o) cyc_tot++;
    if (wb_cyc_o && !cyc_prev) seg_tot++;
    if (proc_err) err_tot++;
    if (proc_stall_pipl) stall_tot++;
    if (wb_cyc_o != wb_stb_o) stb_ne_cyc++;
    cyc_prev = wb_cyc_o;
    if (wb_cyc_o && wb_stb_o) begin
      if (!slv_mute && bus_cnt == slv_wait) begin
        if (rty_given < slv_rty_n) begin
          wb_rty_i = 1'b1;
          rty_given++;
        end else begin
          wb_ack_i = 1'b1;
          wb_dat_i = slv_dat;
          if (slv_mode == 1) wb_err_i = 1'b1;
          if (slv_mode == 2) wb_rty_i = 1'b1;
        end
      end
      bus_cnt++;
    end else begin
      bus_cnt = 0;
    end
    if (!proc_stall_pipl) rty_given = 0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  int d_cyc, d_seg, d_err, d_stall, n_cyc;

  task automatic access(input bit rd, input bit wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata);
    int c0, s0, e0, t0;
    bit done;
    @(posedge clk); #1;
    proc_addr  = addr;
    proc_wdata = wdata;
    proc_op    = op;
    proc_read  = rd;
    proc_write = wr;
    c0 = cyc_tot; s0 = seg_tot; e0 = err_tot; t0 = stall_tot;
    n_cyc = 0;
    done  = 1'b0;
    while (!done && n_cyc < 40) begin
      @(negedge clk); #1;
      n_cyc++;
      if (!proc_stall_pipl) done = 1'b1;
    end
    if (!done) check_eq("access_budget", 32'd0, 32'd1);
    d_cyc = cyc_tot - c0; d_seg = seg_tot - s0; d_err = err_tot - e0; d_stall = stall_tot - t0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctl", {26'd0, wb_cyc_o, wb_stb_o, wb_we_o, proc_stall_pipl, proc_err, 1'b0}, 32'd0);
    check_eq("rst_adr", wb_adr_o, 32'd0);
    check_eq("rst_dat_sel", wb_dat_o | {28'd0, wb_sel_o}, 32'd0);
    check_eq("rst_rdata", proc_rdata, 32'd0);
    check_eq("rst_cti_bte", {27'd0, wb_cti_o, wb_bte_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // SB to byte lane 3, zero-wait slave
    access(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    check_eq("sb_cycles", n_cyc, 3);
    check_eq("sb_stall", d_stall, 2);
    check_eq("sb_cyc", d_cyc, 1);
    check_eq("sb_adr", wb_adr_o, 32'h0000_0100);
    check_eq("sb_sel", {28'd0, wb_sel_o}, 32'h8);
    check_eq("sb_dat", wb_dat_o, 32'hA5A5_A5A5);
    check_eq("sb_we", {31'd0, wb_we_o}, 32'd1);
    check_eq("sb_err", d_err, 0);
    check_eq("sb_rdata", proc_rdata, 32'd0);

    // Halfword loads, signed and unsigned
    slv_dat = 32'h8001_1234;
    access(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'hFFFF_FFFF);
    check_eq("lh_sel", {28'd0, wb_sel_o}, 32'hC);
    check_eq("lh_rdata", proc_rdata, 32'hFFFF_8001);
    check_eq("lh_dat_we", wb_dat_o | {31'd0, wb_we_o}, 32'd0);
    access(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'd0);
    check_eq("lhu_rdata", proc_rdata, 32'h0000_8001);
    access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'd0);
    check_eq("lb_sel", {28'd0, wb_sel_o}, 32'h8);
    check_eq("lb_rdata", proc_rdata, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 3'b100, 32'h0000_0202, 32'd0);
    check_eq("lbu_rdata", proc_rdata, 32'h0000_0001);

    // SH to upper half
    access(1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h1234_BEEF);
    check_eq("sh_adr", wb_adr_o, 32'h0000_0004);
    check_eq("sh_sel", {28'd0, wb_sel_o}, 32'hC);
    check_eq("sh_dat", wb_dat_o, 32'hBEEF_BEEF);
    check_eq("sh_rdata_hold", proc_rdata, 32'h0000_0001);

    // Misaligned LW: no bus cycle, one-cycle error pulse
    access(1'b1, 1'b0, 3'b010, 32'h0000_0301, 32'd0);
    check_eq("mis_cycles", n_cyc, 2);
    check_eq("mis_cyc", d_cyc, 0);
    check_eq("mis_err", d_err, 1);
    check_eq("mis_rdata", proc_rdata, 32'd0);
    @(negedge clk); #1;
    check_eq("mis_err_pulse", {31'd0, proc_err}, 32'd0);

    // Illegal ops: store-unsigned and reserved funct3
    access(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'd0);
    check_eq("ill_sbu", {d_cyc[15:0], d_err[15:0]}, 32'h0000_0001);
    access(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'd0);
    check_eq("ill_011", {d_cyc[15:0], d_err[15:0]}, 32'h0000_0001);

    // Two retries then ack (at RETRY_LIMIT)
    slv_rty_n = 2; slv_dat = 32'hDEAD_BEEF;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
    check_eq("rty2_cycles", n_cyc, 7);
    check_eq("rty2_seg", d_seg, 3);
    check_eq("rty2_cyc", d_cyc, 3);
    check_eq("rty2_err", d_err, 0);
    check_eq("rty2_rdata", proc_rdata, 32'hDEAD_BEEF);

    // Timeout with a silent slave
    slv_rty_n = 0; slv_mute = 1'b1;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'd0);
    check_eq("tmo_cyc", d_cyc, 8);
    check_eq("tmo_cycles", n_cyc, 10);
    check_eq("tmo_err", d_err, 1);
    check_eq("tmo_rdata", proc_rdata, 32'd0);
    slv_mute = 1'b0;

    // Wait-stated load
    slv_wait = 3; slv_dat = 32'hCAFE_F00D;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'd0);
    check_eq("ws_cyc", d_cyc, 4);
    check_eq("ws_rdata", proc_rdata, 32'hCAFE_F00D);
    slv_wait = 0;

    // Retry overflow
    slv_rty_n = 3;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0);
    check_eq("rty3_seg", d_seg, 3);
    check_eq("rty3_err", d_err, 1);
    check_eq("rty3_rdata", proc_rdata, 32'd0);
    slv_rty_n = 0;

    // err beats ack
    slv_dat = 32'h1111_2222; slv_mode = 1;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0);
    check_eq("erracc_err", d_err, 1);
    check_eq("erracc_rdata", proc_rdata, 32'd0);

    // ack beats rty
    slv_mode = 2;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0);
    check_eq("ackrty_cyc", d_cyc, 1);
    check_eq("ackrty_rdata", proc_rdata, 32'h1111_2222);
    slv_mode = 0;

    // Write wins when both requests are set
    access(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344);
    check_eq("ww_we", {31'd0, wb_we_o}, 32'd1);
    check_eq("ww_dat", wb_dat_o, 32'h1122_3344);
    check_eq("ww_rdata_hold", proc_rdata, 32'h1111_2222);

    // Reset in the third BUS cycle of a wait-stated load
    slv_wait = 20;
    @(posedge clk); #1;
    proc_addr = 32'h0000_0700; proc_op = 3'b010; proc_read = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check_eq("mid_pre_cyc", {31'd0, wb_cyc_o}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ctl", {29'd0, wb_cyc_o, wb_stb_o, proc_stall_pipl}, 32'd0);
    check_eq("mid_rst_adr", wb_adr_o, 32'd0);
    check_eq("mid_rst_rdata", proc_rdata, 32'd0);
    proc_read = 1'b0;
    slv_wait = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    slv_dat = 32'h1357_9BDF;
    access(1'b1, 1'b0, 3'b010, 32'h0000_0704, 32'd0);
    check_eq("post_cycles", n_cyc, 3);
    check_eq("post_err", d_err, 0);
    check_eq("post_rdata", proc_rdata, 32'h1357_9BDF);
    check_eq("post_adr", wb_adr_o, 32'h0000_0704);

    check_eq("stb_eq_cyc", stb_ne_cyc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
